// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port synchronous RAM between an instruction-fetch read
//   port and a data read/write port. Data requests normally win; a fetch that
//   has been denied STARVE_LIMIT consecutive cycles wins the next contention.
//   Grants are combinational so a winning request is accepted the cycle it
//   first appears. Read data returns one cycle after acceptance, steered to
//   the requester by a small read-return state register.
//
// Ports
//   clk, reset_n                   clock, asynchronous active-low reset
//   if_req / if_address            fetch read request and address
//   if_ready / if_valid / if_data  fetch accept, read-return strobe, read data
//   mem_req / mem_wren             data request, 1 = write
//   mem_address / mem_write_data   data address and write data
//   mem_ready / mem_valid          data accept, read-return strobe
//   mem_data                       data read result
//   ram_address / ram_write_data   RAM address and write data
//   ram_wren / ram_data            RAM write strobe, RAM read data (1-cycle)
module ram_arbiter #(
   parameter int ADDR_WIDTH   = 15,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_address,
   output logic                  if_ready,
   output logic                  if_valid,
   output logic [31:0]           if_data,
   input  logic                  mem_req,
   input  logic                  mem_wren,
   input  logic [ADDR_WIDTH-1:0] mem_address,
   input  logic [31:0]           mem_write_data,
   output logic                  mem_ready,
   output logic                  mem_valid,
   output logic [31:0]           mem_data,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [31:0]           ram_write_data,
   output logic                  ram_wren,
   input  logic [31:0]           ram_data
);

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      IF_RD  = 2'd1,
      MEM_RD = 2'd2
   } rd_state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   rd_state_t             rd_state_p1;
   logic [3:0]            starve_cnt;
   logic [ADDR_WIDTH-1:0] addr_hold_p1;
   logic                  fetch_win;
   logic                  if_grant;
   logic                  mem_grant;

   // Stage p0: combinational arbitration on the live requests.
   // Grants are forced low while reset is held so nothing reaches the RAM.
   always_comb begin
      fetch_win = if_req && (!mem_req || (starve_cnt == STARVE_MAX));
      if_grant  = reset_n && fetch_win;
      mem_grant = reset_n && mem_req && !fetch_win;
   end

   assign if_ready       = if_grant;
   assign mem_ready      = mem_grant;
   assign ram_wren       = mem_grant && mem_wren;
   assign ram_write_data = mem_write_data;

   // With no winner the RAM keeps seeing the previous address.
   always_comb begin
      ram_address = addr_hold_p1;
      if (if_grant)
         ram_address = if_address;
      else if (mem_grant)
         ram_address = mem_address;
   end

   // Stage p1: read-return state, starvation counter, held address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_state_p1  <= NONE;
         starve_cnt   <= 4'd0;
         addr_hold_p1 <= '0;
      end else begin
         if (if_grant)
            rd_state_p1 <= IF_RD;
         else if (mem_grant && !mem_wren)
            rd_state_p1 <= MEM_RD;
         else
            rd_state_p1 <= NONE;

         if (if_req && !if_grant)
            starve_cnt <= (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 4'd1;
         else
            starve_cnt <= 4'd0;

         addr_hold_p1 <= ram_address;
      end
   end

   // Stage p2: RAM output is steered by the state captured at acceptance.
   assign if_valid  = (rd_state_p1 == IF_RD);
   assign mem_valid = (rd_state_p1 == MEM_RD);
   assign if_data   = ram_data;
   assign mem_data  = ram_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: behavioural RAM, a spec-level reference model
// (grant rule, starvation count, shadow memory, expected read returns),
// one per-cycle compare process, directed scenarios pinned with literals,
// and a randomized traffic phase.
module tb_ram_arbiter;
   localparam int AW    = 15;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          if_req, mem_req, mem_wren;
   logic [AW-1:0] if_address, mem_address;
   logic [31:0]   mem_write_data;
   logic          if_ready, if_valid, mem_ready, mem_valid, ram_wren;
   logic [31:0]   if_data, mem_data, ram_write_data, ram_data;
   logic [AW-1:0] ram_address;

   int n_cmp = 0;
   int n_err = 0;

   ram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_address(if_address), .if_ready(if_ready),
      .if_valid(if_valid), .if_data(if_data),
      .mem_req(mem_req), .mem_wren(mem_wren), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_ready(mem_ready),
      .mem_valid(mem_valid), .mem_data(mem_data),
      .ram_address(ram_address), .ram_write_data(ram_write_data),
      .ram_wren(ram_wren), .ram_data(ram_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input logic [7:0] a);
      return {24'hC0DE00, a};
   endfunction

   // Environment: synchronous single-port RAM, write-before-read.
   logic [31:0] ram_arr [0:255];
   always @(posedge clk) begin
      if (ram_wren) begin
         ram_arr[ram_address[7:0]] <= ram_write_data;
         ram_data <= ram_write_data;
      end else begin
         ram_data <= ram_arr[ram_address[7:0]];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: 0 = no grant, 1 = fetch, 2 = data.
   function automatic logic [1:0] model_grant(input logic ir, input logic mr, input int starve);
      if (ir && (!mr || starve >= LIMIT)) return 2'd1;
      if (mr) return 2'd2;
      return 2'd0;
   endfunction

   logic [31:0]   shadow [0:255];
   int            m_starve;
   logic [1:0]    m_pend;
   logic [31:0]   m_data;
   logic [AW-1:0] m_last;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_starve <= 0;
         m_pend   <= 2'd0;
         m_last   <= '0;
      end else begin
         case (model_grant(if_req, mem_req, m_starve))
            2'd1: begin
               m_pend <= 2'd1;
               m_data <= shadow[if_address[7:0]];
               m_last <= if_address;
            end
            2'd2: begin
               m_last <= mem_address;
               if (mem_wren) begin
                  shadow[mem_address[7:0]] <= mem_write_data;
                  m_pend <= 2'd0;
               end else begin
                  m_pend <= 2'd2;
                  m_data <= shadow[mem_address[7:0]];
               end
            end
            default: m_pend <= 2'd0;
         endcase
         if (if_req && model_grant(if_req, mem_req, m_starve) != 2'd1)
            m_starve <= (m_starve < LIMIT) ? m_starve + 1 : m_starve;
         else
            m_starve <= 0;
      end
   end

   // Compare process: inputs are stable from posedge+1 to the next posedge.
   always @(negedge clk) begin
      logic [1:0]    g;
      logic [AW-1:0] ea;
      if (!reset_n) begin
         chk("rst_if_ready",  64'(if_ready),    64'(0));
         chk("rst_mem_ready", 64'(mem_ready),   64'(0));
         chk("rst_if_valid",  64'(if_valid),    64'(0));
         chk("rst_mem_valid", 64'(mem_valid),   64'(0));
         chk("rst_ram_wren",  64'(ram_wren),    64'(0));
         chk("rst_ram_addr",  64'(ram_address), 64'(0));
      end else begin
         g  = model_grant(if_req, mem_req, m_starve);
         ea = (g == 2'd1) ? if_address : (g == 2'd2) ? mem_address : m_last;
         chk("if_ready",  64'(if_ready),  64'(g == 2'd1));
         chk("mem_ready", 64'(mem_ready), 64'(g == 2'd2));
         chk("one_grant", 64'(if_ready && mem_ready), 64'(0));
         chk("ram_wren",  64'(ram_wren),  64'(g == 2'd2 && mem_wren));
         chk("ram_addr",  64'(ram_address), 64'(ea));
         if (g == 2'd2 && mem_wren)
            chk("ram_wdata", 64'(ram_write_data), 64'(mem_write_data));
         chk("if_valid",  64'(if_valid),  64'(m_pend == 2'd1));
         chk("mem_valid", 64'(mem_valid), 64'(m_pend == 2'd2));
         if (m_pend == 2'd1) chk("if_data",  64'(if_data),  64'(m_data));
         if (m_pend == 2'd2) chk("mem_data", 64'(mem_data), 64'(m_data));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [9:0] pat;
      logic       acc_if, acc_mem;
      for (int i = 0; i < 256; i++) begin
         ram_arr[i] = init_word(8'(i));
         shadow[i]  = init_word(8'(i));
      end
      reset_n = 1'b0; if_req = 1'b1; mem_req = 1'b0; mem_wren = 1'b0;
      if_address = '0; mem_address = '0; mem_write_data = '0;
      repeat (3) cyc();
      chk("lit_rst_ready", 64'(if_ready), 64'(0));
      chk("lit_rst_addr",  64'(ram_address), 64'(0));
      if_req = 1'b0; reset_n = 1'b1;

      // Three consecutive fetches.
      cyc(); if_req = 1'b1; if_address = 15'h10;
      #2 chk("lit_f0_ready", 64'(if_ready), 64'(1));
      cyc(); if_address = 15'h14;
      #2 chk("lit_f1_data", 64'(if_data), 64'(32'hC0DE0010));
      chk("lit_f1_valid", 64'(if_valid), 64'(1));
      cyc(); if_address = 15'h18;
      #2 chk("lit_f2_data", 64'(if_data), 64'(32'hC0DE0014));
      cyc(); if_req = 1'b0;
      #2 chk("lit_f3_data", 64'(if_data), 64'(32'hC0DE0018));
      cyc();
      #2 chk("lit_f4_valid", 64'(if_valid), 64'(0));

      // Both requesting every cycle: four data grants, then one fetch.
      if_req = 1'b1; mem_req = 1'b1; mem_wren = 1'b0;
      if_address = 15'h40; mem_address = 15'h41;
      for (int i = 0; i < 10; i++) begin
         #2 pat[i] = if_ready;
         cyc();
      end
      chk("lit_starve_pattern", 64'(pat), 64'(10'b1000010000));
      if_req = 1'b0; mem_req = 1'b0;

      // Write then read-back of the same address.
      cyc(); mem_req = 1'b1; mem_wren = 1'b1; mem_address = 15'h20;
      mem_write_data = 32'hDEADBEEF;
      #2 chk("lit_wr_wren", 64'(ram_wren), 64'(1));
      cyc(); mem_wren = 1'b0;
      #2 chk("lit_rd_wren", 64'(ram_wren), 64'(0));
      chk("lit_wr_novalid", 64'(mem_valid), 64'(0));
      cyc(); mem_req = 1'b0;
      #2 chk("lit_rd_valid", 64'(mem_valid), 64'(1));
      chk("lit_rd_data", 64'(mem_data), 64'(32'hDEADBEEF));

      // Alternating fetch / data reads.
      for (int i = 0; i < 6; i++) begin
         cyc();
         if_req = ((i % 2) == 0); mem_req = ((i % 2) == 1); mem_wren = 1'b0;
         if_address = 15'(8'h50 + i); mem_address = 15'(8'h50 + i);
      end
      cyc(); if_req = 1'b0; mem_req = 1'b0;
      #2 chk("lit_alt_mvalid", 64'(mem_valid), 64'(1));
      chk("lit_alt_ivalid", 64'(if_valid), 64'(0));
      chk("lit_alt_data", 64'(mem_data), 64'(32'hC0DE0055));

      // Random traffic; requests are held until accepted.
      acc_if = 1'b0; acc_mem = 1'b0;
      for (int i = 0; i < 400; i++) begin
         cyc();
         if (!if_req || acc_if) begin
            if_req = ($urandom_range(0, 99) < 55);
            if_address = 15'($urandom_range(0, 127));
         end
         if (!mem_req || acc_mem) begin
            mem_req = ($urandom_range(0, 99) < 55);
            mem_wren = ($urandom_range(0, 99) < 40);
            mem_address = 15'($urandom_range(0, 127));
            mem_write_data = $urandom;
         end
         #2 acc_if = if_ready; acc_mem = mem_ready;
      end

      // Idle after traffic: address holds, nothing strobes.
      cyc(); if_req = 1'b1; mem_req = 1'b0; if_address = 15'h33;
      cyc(); if_req = 1'b0;
      repeat (10) cyc();
      #2 chk("lit_idle_addr", 64'(ram_address), 64'(15'h33));
      chk("lit_idle_wren", 64'(ram_wren), 64'(0));
      chk("lit_idle_valid", 64'(if_valid || mem_valid), 64'(0));

      // Reset arrives after a fetch is accepted but before the edge.
      cyc(); if_req = 1'b1; if_address = 15'h60;
      #2 chk("lit_pre_rst_ready", 64'(if_ready), 64'(1));
      #4 reset_n = 1'b0;
      #1 chk("lit_rst_mid_valid", 64'(if_valid), 64'(0));
      chk("lit_rst_mid_ready", 64'(if_ready), 64'(0));
      cyc(); cyc();
      if_address = 15'hE0; reset_n = 1'b1;
      #1 chk("lit_resume_ready", 64'(if_ready), 64'(1));
      chk("lit_post_rst_valid", 64'(if_valid), 64'(0));
      cyc(); if_req = 1'b0;
      #2 chk("lit_resume_valid", 64'(if_valid), 64'(1));
      chk("lit_resume_data", 64'(if_data), 64'(32'hC0DE00E0));
      cyc(); cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
